// File: rtl/bus_arb_xbar.sv
// bus_arb_xbar: multi-host to multi-device system bus crossbar.
//   Hosts are arbitrated round-robin. The winner's address is decoded against
//   per-device base/mask tables, and one transaction is in flight at a time.
//   Unmapped addresses complete with a decode error. Devices that stay silent
//   for TimeoutCycles complete with a timeout error.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   host_req/addr/we/be/wdata_i [H]      host request channel
//   host_gnt_o [H]                       combinational grant (IDLE only)
//   host_rvalid/rdata/err_o [H]          host response channel
//   device_req/addr/we/be/wdata_o [D]    one-cycle request pulse + fields
//   device_rvalid/rdata/err_i [D]        device response channel
//   cfg_device_addr_base/mask [D]        decode tables
module bus_arb_xbar #(
    parameter int NrHosts       = 2,
    parameter int NrDevices     = 8,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    host_req_i           [NrHosts],
    output logic                    host_gnt_o           [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i          [NrHosts],
    input  logic                    host_we_i            [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i         [NrHosts],
    output logic                    host_rvalid_o        [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o         [NrHosts],
    output logic                    host_err_o           [NrHosts],
    output logic                    device_req_o         [NrDevices],
    output logic [AddressWidth-1:0] device_addr_o        [NrDevices],
    output logic                    device_we_o          [NrDevices],
    output logic [DataWidth/8-1:0]  device_be_o          [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o       [NrDevices],
    input  logic                    device_rvalid_i      [NrDevices],
    input  logic [DataWidth-1:0]    device_rdata_i       [NrDevices],
    input  logic                    device_err_i         [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);
    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int CntW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0]     CntMax      = CntW'(TimeoutCycles);
    localparam logic [HostIdxW-1:0] LastHostRst = HostIdxW'(NrHosts - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DERR} state_e;

    // The hit/miss outcome of the latched request is carried by the state
    // itself (WAIT = hit, DERR = miss).
    state_e              state_q, state_d;
    logic [HostIdxW-1:0] host_q, host_d;
    logic [HostIdxW-1:0] last_host_q, last_host_d;
    logic [DevIdxW-1:0]  dev_q, dev_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    // Round-robin pick: scan starting one past the last winner.
    logic                arb_found;
    logic [HostIdxW-1:0] arb_idx;
    int                  cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NrHosts; i++) begin
            cand = int'(last_host_q) + i;
            if (cand >= NrHosts) cand = cand - NrHosts;
            if (!arb_found && host_req_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = HostIdxW'(cand);
            end
        end
    end

    // Address decode of the winning host; the lowest matching index wins.
    logic               dec_hit;
    logic [DevIdxW-1:0] dec_idx;

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!dec_hit &&
                ((host_addr_i[arb_idx] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
                dec_hit = 1'b1;
                dec_idx = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        host_d      = host_q;
        last_host_d = last_host_q;
        dev_d       = dev_q;
        cnt_d       = cnt_q;
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = 1'b0;
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = 1'b0;
            device_addr_o[d]  = '0;
            device_we_o[d]    = 1'b0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
        end

        case (state_q)
            S_IDLE: begin
                // Gated by rst_ni so that held requests cannot raise a grant
                // while the block is in reset.
                if (rst_ni && arb_found) begin
                    host_gnt_o[arb_idx] = 1'b1;
                    last_host_d         = arb_idx;
                    host_d              = arb_idx;
                    dev_d               = dec_idx;
                    cnt_d               = '0;
                    if (dec_hit) begin
                        device_req_o[dec_idx]   = 1'b1;
                        device_addr_o[dec_idx]  = host_addr_i[arb_idx];
                        device_we_o[dec_idx]    = host_we_i[arb_idx];
                        device_be_o[dec_idx]    = host_be_i[arb_idx];
                        device_wdata_o[dec_idx] = host_wdata_i[arb_idx];
                        state_d                 = S_WAIT;
                    end else begin
                        state_d = S_DERR;
                    end
                end
            end
            S_WAIT: begin
                if (device_rvalid_i[dev_q]) begin
                    host_rvalid_o[host_q] = 1'b1;
                    host_rdata_o[host_q]  = device_rdata_i[dev_q];
                    host_err_o[host_q]    = device_err_i[dev_q];
                    state_d               = S_IDLE;
                end else if (TimeoutCycles != 0 && cnt_q == CntMax) begin
                    host_rvalid_o[host_q] = 1'b1;
                    host_err_o[host_q]    = 1'b1;
                    state_d               = S_IDLE;
                end else if (cnt_q != CntMax) begin
                    // Saturates instead of wrapping (relevant when timeout is off).
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DERR: begin
                host_rvalid_o[host_q] = 1'b1;
                host_err_o[host_q]    = 1'b1;
                state_d               = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            host_q      <= '0;
            last_host_q <= LastHostRst;
            dev_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            host_q      <= host_d;
            last_host_q <= last_host_d;
            dev_q       <= dev_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bus_arb_xbar.sv
// Directed bench for bus_arb_xbar: a cycle-by-cycle vector table covers
// decode, arbitration and response forwarding. Hand-written sequences
// cover timeout and reset in the middle of a transaction.
module tb_bus_arb_xbar;
    localparam int H = 2;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req [H];
    logic        host_gnt [H];
    logic [31:0] host_addr [H];
    logic        host_we [H];
    logic [3:0]  host_be [H];
    logic [31:0] host_wdata [H];
    logic        host_rvalid [H];
    logic [31:0] host_rdata [H];
    logic        host_err [H];
    logic        dev_req [D];
    logic [31:0] dev_addr [D];
    logic        dev_we [D];
    logic [3:0]  dev_be [D];
    logic [31:0] dev_wdata [D];
    logic        dev_rvalid [D];
    logic [31:0] dev_rdata [D];
    logic        dev_err [D];
    logic [31:0] cfg_base [D];
    logic [31:0] cfg_mask [D];

    bus_arb_xbar #(
        .NrHosts(H), .NrDevices(D), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
        .device_be_o(dev_be), .device_wdata_o(dev_wdata),
        .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    always #5 clk = ~clk;

    // Packed views of the DUT outputs for compact comparison.
    logic [1:0]  gnt_v, rv_v, err_v;
    logic [7:0]  dreq_v;
    logic [31:0] daddr_or;
    logic [36:0] dfld_or;
    always_comb begin
        gnt_v = '0; rv_v = '0; err_v = '0; dreq_v = '0; daddr_or = '0; dfld_or = '0;
        for (int h = 0; h < H; h++) begin
            gnt_v[h] = host_gnt[h];
            rv_v[h]  = host_rvalid[h];
            err_v[h] = host_err[h];
        end
        for (int d = 0; d < D; d++) begin
            dreq_v[d] = dev_req[d];
            daddr_or  = daddr_or | dev_addr[d];
            dfld_or   = dfld_or | {dev_we[d], dev_be[d], dev_wdata[d]};
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic [7:0]  drv, derr;
        logic [31:0] rdata;
        logic [1:0]  gnt;
        logic [7:0]  dreq;
        logic [31:0] daddr;
        logic [1:0]  rv, err;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs [18];

    // Fixed per-host write fields, used to check forwarding to the device.
    localparam logic [36:0] Fld0 = {1'b0, 4'hF, 32'hA0A0_A0A0};
    localparam logic [36:0] Fld1 = {1'b1, 4'h3, 32'hB1B1_B1B1};

    task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [7:0] drv, input logic [7:0] derr, input logic [31:0] rdata);
        host_req[0] = req[0]; host_req[1] = req[1];
        host_addr[0] = a0;    host_addr[1] = a1;
        for (int d = 0; d < D; d++) begin
            dev_rvalid[d] = drv[d];
            dev_err[d]    = derr[d];
            dev_rdata[d]  = rdata;
        end
    endtask

    int          first_rv;
    int          pulses;
    logic [36:0] exp_fld;

    initial begin
        host_we[0] = Fld0[36]; host_be[0] = Fld0[35:32]; host_wdata[0] = Fld0[31:0];
        host_we[1] = Fld1[36]; host_be[1] = Fld1[35:32]; host_wdata[1] = Fld1[31:0];
        // 0 RAM, 1 GPIO, 2/5 overlap at 0x8000_2000, 3/4/6/7 filler.
        cfg_base[0] = 32'h0000_0000; cfg_mask[0] = 32'hFFF0_0000;
        cfg_base[1] = 32'h8000_0000; cfg_mask[1] = 32'hFFFF_F000;
        cfg_base[2] = 32'h8000_2000; cfg_mask[2] = 32'hFFFF_F000;
        cfg_base[3] = 32'h8000_3000; cfg_mask[3] = 32'hFFFF_F000;
        cfg_base[4] = 32'h8000_4000; cfg_mask[4] = 32'hFFFF_F000;
        cfg_base[5] = 32'h8000_2000; cfg_mask[5] = 32'hFFFF_FF00;
        cfg_base[6] = 32'h8000_6000; cfg_mask[6] = 32'hFFFF_F000;
        cfg_base[7] = 32'h8000_7000; cfg_mask[7] = 32'hFFFF_F000;

        //            req    a0            a1            drv    derr   rdata         gnt    dreq   daddr         rv     err    rd0           rd1
        vecs[0]  = '{2'b01, 32'h0000_0010, 32'h0,        8'h00, 8'h00, 32'h0,        2'b01, 8'h01, 32'h0000_0010, 2'b00, 2'b00, 32'h0,        32'h0};
        vecs[1]  = '{2'b00, 32'h0000_0010, 32'h0,        8'h01, 8'h00, 32'hDEADBEEF, 2'b00, 8'h00, 32'h0,        2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{2'b00, 32'h0,        32'h0,        8'h01, 8'h00, 32'h1234_5678, 2'b00, 8'h00, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
        vecs[3]  = '{2'b10, 32'h0,        32'h4000_0000, 8'h00, 8'h00, 32'h0,        2'b10, 8'h00, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
        vecs[4]  = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 32'h0,        2'b00, 8'h00, 32'h0,        2'b10, 2'b10, 32'h0,        32'h0};
        vecs[5]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 8'h00, 8'h00, 32'h0,      2'b01, 8'h02, 32'h8000_0000, 2'b00, 2'b00, 32'h0,        32'h0};
        vecs[6]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 8'h02, 8'h00, 32'h1111_1111, 2'b00, 8'h00, 32'h0,    2'b01, 2'b00, 32'h1111_1111, 32'h0};
        vecs[7]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 8'h00, 8'h00, 32'h0,      2'b10, 8'h02, 32'h8000_0000, 2'b00, 2'b00, 32'h0,        32'h0};
        vecs[8]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 8'h02, 8'h00, 32'h2222_2222, 2'b00, 8'h00, 32'h0,    2'b10, 2'b00, 32'h0,        32'h2222_2222};
        vecs[9]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 8'h00, 8'h00, 32'h0,      2'b01, 8'h02, 32'h8000_0000, 2'b00, 2'b00, 32'h0,        32'h0};
        vecs[10] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 8'h04, 8'h00, 32'h9999_9999, 2'b00, 8'h00, 32'h0,    2'b00, 2'b00, 32'h0,        32'h0};
        vecs[11] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 8'h02, 8'h00, 32'h3333_3333, 2'b00, 8'h00, 32'h0,    2'b01, 2'b00, 32'h3333_3333, 32'h0};
        vecs[12] = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 32'h0,        2'b00, 8'h00, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
        vecs[13] = '{2'b10, 32'h0,        32'h8000_2004, 8'h00, 8'h00, 32'h0,        2'b10, 8'h04, 32'h8000_2004, 2'b00, 2'b00, 32'h0,        32'h0};
        vecs[14] = '{2'b00, 32'h0,        32'h0,        8'h04, 8'h04, 32'h5A5A_5A5A, 2'b00, 8'h00, 32'h0,        2'b10, 2'b10, 32'h0,        32'h5A5A_5A5A};
        vecs[15] = '{2'b01, 32'h8000_2004, 32'h0,        8'h00, 8'h00, 32'h0,        2'b01, 8'h04, 32'h8000_2004, 2'b00, 2'b00, 32'h0,        32'h0};
        vecs[16] = '{2'b00, 32'h0,        32'h0,        8'h00, 8'h00, 32'h0,        2'b00, 8'h00, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
        vecs[17] = '{2'b00, 32'h0,        32'h0,        8'h04, 8'h00, 32'h0BAD_F00D, 2'b00, 8'h00, 32'h0,        2'b01, 2'b00, 32'h0BAD_F00D, 32'h0};

        drive(2'b00, 32'h0, 32'h0, 8'h00, 8'h00, 32'h0);
        #3;
        chk("rst_gnt", 64'(gnt_v), 64'h0);
        chk("rst_dreq", 64'(dreq_v), 64'h0);
        chk("rst_rv", 64'(rv_v), 64'h0);
        chk("rst_rdata", 64'(host_rdata[0] | host_rdata[1]), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cycle-by-cycle vector table.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].drv, vecs[i].derr, vecs[i].rdata);
            #4;
            exp_fld = (vecs[i].dreq == 8'h00) ? 37'h0 : ((vecs[i].gnt == 2'b01) ? Fld0 : Fld1);
            chk($sformatf("v%0d_gnt", i),   64'(gnt_v),         64'(vecs[i].gnt));
            chk($sformatf("v%0d_dreq", i),  64'(dreq_v),        64'(vecs[i].dreq));
            chk($sformatf("v%0d_daddr", i), 64'(daddr_or),      64'(vecs[i].daddr));
            chk($sformatf("v%0d_dfld", i),  64'(dfld_or),       64'(exp_fld));
            chk($sformatf("v%0d_rv", i),    64'(rv_v),          64'(vecs[i].rv));
            chk($sformatf("v%0d_err", i),   64'(err_v),         64'(vecs[i].err));
            chk($sformatf("v%0d_rd0", i),   64'(host_rdata[0]), 64'(vecs[i].rd0));
            chk($sformatf("v%0d_rd1", i),   64'(host_rdata[1]), 64'(vecs[i].rd1));
            @(posedge clk); #1;
        end

        // Timeout: host1 to RAM, device silent; a late response is ignored.
        drive(2'b10, 32'h0, 32'h0000_0010, 8'h00, 8'h00, 32'h7777_7777);
        #4;
        chk("to_gnt", 64'(gnt_v), 64'h2);
        chk("to_dreq", 64'(dreq_v), 64'h01);
        first_rv = 0;
        pulses   = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            drive(2'b00, 32'h0, 32'h0, (k >= 6) ? 8'h01 : 8'h00, 8'h00, 32'h7777_7777);
            #4;
            if (rv_v != 2'b00) begin
                pulses++;
                if (first_rv == 0) begin
                    first_rv = k;
                    chk("to_err", 64'(err_v), 64'h2);
                    chk("to_rdata", 64'(host_rdata[1]), 64'h0);
                end
            end
        end
        chk("to_latency", 64'(first_rv), 64'd5);
        chk("to_pulses", 64'(pulses), 64'd1);

        // Reset mid-transaction: host0 granted (last_host=0), then reset in WAIT.
        @(posedge clk); #1;
        drive(2'b01, 32'h0000_0010, 32'h0000_0010, 8'h00, 8'h00, 32'h0);
        #4;
        chk("mr_gnt", 64'(gnt_v), 64'h1);
        @(posedge clk); #1;
        drive(2'b11, 32'h0000_0010, 32'h0000_0010, 8'h01, 8'h00, 32'hCAFE_CAFE);
        rst_n = 1'b0;
        #4;
        chk("mr_rst_gnt", 64'(gnt_v), 64'h0);
        chk("mr_rst_dreq", 64'(dreq_v), 64'h0);
        chk("mr_rst_rv", 64'(rv_v), 64'h0);
        chk("mr_rst_rdata", 64'(host_rdata[0] | host_rdata[1]), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(2'b11, 32'h0000_0010, 32'h0000_0010, 8'h00, 8'h00, 32'h0);
        #4;
        chk("mr_first_gnt", 64'(gnt_v), 64'h1);
        @(posedge clk); #1;
        drive(2'b00, 32'h0, 32'h0, 8'h01, 8'h00, 32'h600D_600D);
        #4;
        chk("mr_resp_rv", 64'(rv_v), 64'h1);
        chk("mr_resp_rd0", 64'(host_rdata[0]), 64'h600D_600D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arb_xbar.md
# bus_arb_xbar

Parametrised successor to the single-host system bus. It connects `NrHosts` bus hosts (core data port, debug SBA, future DMA) to `NrDevices` memory-mapped devices. Hosts are arbitrated round-robin. Addresses are decoded against base/mask tables. Unmapped accesses return a decode error, and devices that do not respond within a programmable window get a timeout error. It sits between the core/debug hosts and RAM, GPIO, PWM, UART, timer, SPI and sim-control in the demo system top level.

## Interface
Parameters:
- `NrHosts`, 2: number of hosts (≥1).
- `NrDevices`, 8: number of devices (≥1).
- `DataWidth`, 32: data width; must be a multiple of 8.
- `AddressWidth`, 32: address width.
- `TimeoutCycles`, 255: maximum cycles spent waiting for a device response; 0 disables the timeout.

Ports (arrays unpacked, indexed by host/device):
- `clk_i` in 1: the block's single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `host_req_i[NrHosts]` in 1: host request.
- `host_gnt_o[NrHosts]` out 1: host grant.
- `host_addr_i[NrHosts]` in AddressWidth: byte address.
- `host_we_i[NrHosts]` in 1: write enable.
- `host_be_i[NrHosts]` in DataWidth/8: byte enables.
- `host_wdata_i[NrHosts]` in DataWidth: write data.
- `host_rvalid_o[NrHosts]` out 1: response valid.
- `host_rdata_o[NrHosts]` out DataWidth: read data.
- `host_err_o[NrHosts]` out 1: response error; valid with `host_rvalid_o`.
- `device_req_o[NrDevices]` out 1: device request, one-cycle pulse.
- `device_addr_o`, `device_we_o`, `device_be_o`, `device_wdata_o` `[NrDevices]` out: forwarded request fields.
- `device_rvalid_i[NrDevices]` in 1: device response valid.
- `device_rdata_i[NrDevices]` in DataWidth: device read data.
- `device_err_i[NrDevices]` in 1: device error.
- `cfg_device_addr_base[NrDevices]` in AddressWidth: decode base address.
- `cfg_device_addr_mask[NrDevices]` in AddressWidth: decode mask.

## Operation
- FSM states: IDLE, WAIT, DERR.
- **IDLE arbitration**
  - Round-robin among asserted `host_req_i`.
  - Search starts at `last_host+1`, modulo NrHosts.
  - `last_host` resets to NrHosts-1, so host 0 wins first.
- **IDLE decode**
  - Device d hits when `(addr & mask[d]) == base[d]`.
  - If several devices hit, the lowest index wins.
- **Grant cycle**
  - `host_gnt_o[h]` is asserted combinationally in the same cycle as `host_req_i[h]`.
  - `last_host` ← h.
  - Latched: h, d and the hit flag.
- **Hit**
  - `device_req_o[d]` pulses for the grant cycle.
  - `device_addr_o[d]`, `device_we_o[d]`, `device_be_o[d]` and `device_wdata_o[d]` carry host h's fields.
  - All other device outputs are 0.
  - Next state is WAIT; the timeout counter is cleared.
- **Miss**
  - No device request is issued.
  - Next state is DERR.
- **DERR**
  - Lasts one cycle.
  - `host_rvalid_o[h]`=1, `host_err_o[h]`=1, `host_rdata_o[h]`=0.
  - Next state is IDLE.
- **WAIT, normal completion**
  - `device_rvalid_i[d]` is forwarded combinationally to host h: `host_rvalid_o[h]`=1, with `host_rdata_o[h]`/`host_err_o[h]` taken from device d.
  - Next state is IDLE.
- **WAIT, timeout**
  - Without rvalid, the counter increments.
  - When the counter equals TimeoutCycles (TimeoutCycles≠0), host h gets rvalid=1, err=1, rdata=0, and the FSM goes to IDLE.
  - Counter width is `$clog2(TimeoutCycles+1)`; it never wraps.
- **Ignored device responses:** `device_rvalid_i` outside WAIT, or from a device other than d, is ignored. This includes late responses after a timeout.
- **Single outstanding transaction:** no grant is issued in WAIT or DERR; requests are held by the hosts.
- **Idle outputs:** `host_rdata_o` is 0 whenever the corresponding rvalid is 0.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0, `last_host`=NrHosts-1.
- **Reset mid-transaction:** the transaction is abandoned with no response, and the FSM returns to IDLE.
- **Grant latency:** 0 cycles (combinational from req in IDLE).
- **Response latency:** device latency L≥1 gives host rvalid L cycles after the grant; DERR gives rvalid 1 cycle after the grant.
- **Timeout:** rvalid+err asserted exactly TimeoutCycles+1 cycles after the grant.
- **Throughput:** at most one transaction per L+1 cycles; IDLE always takes one cycle after completion.
- **Fairness:** with all hosts requesting continuously, grants rotate 0,1,…,NrHosts-1,0.

## Test plan
- **Single host, RAM read:** host0 reads 0x0000_0010 and RAM answers with L=1, rdata 0xDEADBEEF → gnt at cycle 0; host_rvalid at cycle 1 with rdata 0xDEADBEEF, err 0.
- **Contention:** both hosts request continuously to GPIO 0x8000_0000 with L=1 → grants alternate 0,1,0,1 every 2 cycles; device_req never asserted in the cycle following a grant.
- **Decode error:** host1 reads 0x4000_0000 (unmapped) → gnt, no device_req, next cycle rvalid=1, err=1, rdata=0.
- **Timeout:** TimeoutCycles=4, device never responds → rvalid+err at cycle 5 after grant; a later device_rvalid_i produces no host rvalid.
- **Overlapping decode and error propagation:** device 2 and device 5 both match 0x8000_2004 → only device_req_o[2] pulses; device_err_i[2]=1 is passed to the host as err=1.
- **Reset mid-operation:** rst_ni asserted in WAIT → all outputs 0; after release, host0 is granted first.
